// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo_sync write port among NUM_REQ valid/ready
// byte producers; each grant lasts up to MAX_BURST beats before rotating.

module fifo_wr_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  gnt,
  input  logic                  open,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_gated
);
  assign ready      = gnt & open;
  assign data_gated = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  input  logic                          fifo_ready,
  output logic [NUM_REQ-1:0]            grant
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                             state, state_n;
  logic [NUM_REQ-1:0]                 grant_n;
  logic [IW-1:0]                      last, last_n, gidx;
  logic [CW-1:0]                      cnt, cnt_n;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
  logic                               open, beat, last_beat;

  assign open = ~fifo_full & fifo_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .gnt        (grant[i]),
      .open       (open),
      .data       (req_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .ready      (req_ready[i]),
      .data_gated (lane_data[i])
    );
  end

  // grant is one-hot, so OR-ing the gated lanes is the data mux
  always_comb begin
    fifo_wr_data = '0;
    for (int k = 0; k < NUM_REQ; k++) fifo_wr_data |= lane_data[k];
  end

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NUM_REQ; k++) if (grant[k]) gidx = IW'(k);
  end

  assign beat       = |(grant & req_valid) & open;
  assign fifo_wr_en = beat;
  assign last_beat  = beat && (cnt == CW'(MAX_BURST - 1));

  // first valid requester after base, wrapping; base itself is checked last
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [IW-1:0]      base);
    logic [NUM_REQ-1:0] oh;
    logic               found;
    int                 idx;
    oh    = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(base) + k) % NUM_REQ;
      if (!found && v[idx]) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (fifo_ready && |req_valid) begin
          grant_n = rr_pick(req_valid, last);
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!fifo_ready) begin
          grant_n = '0;
          state_n = IDLE;
        end else if (last_beat || !req_valid[gidx]) begin
          // re-arbitrate in the same cycle so rotation costs no bubble
          last_n = gidx;
          cnt_n  = '0;
          if (|req_valid) begin
            grant_n = rr_pick(req_valid, gidx);
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end else if (beat) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(NUM_REQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter (3 requesters): directed scenarios plus a randomized
// run, all checked against a cycle-level behavioural model and a scoreboard.

module tb_fifo_wr_arbiter;
  localparam int NR = 3, DW = 8, MB = 4;

  logic              clk = 1'b0, rst = 1'b1;
  logic [NR-1:0]     req_valid, req_ready, grant;
  logic [NR*DW-1:0]  req_data;
  logic              fifo_wr_en, fifo_full, fifo_ready;
  logic [DW-1:0]     fifo_wr_data;
  logic [2*NR+DW:0]  obs, e_vec;
  int                n_cmp = 0, n_err = 0;
  int                m_owner, m_cnt, m_last;
  int                seq [NR];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .fifo_ready(fifo_ready), .grant(grant)
  );

  assign obs = {grant, req_ready, fifo_wr_en, fifo_wr_data};

  // model: owner index (-1 = nobody), beats taken in this grant, last released owner
  function automatic int pick(int from);
    for (int k = 1; k <= NR; k++)
      if (req_valid[(from + k) % NR]) return (from + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = NR - 1;
  endtask

  task automatic model_step();
    logic [NR-1:0] eg, er;
    logic          ew, open;
    logic [DW-1:0] ed;
    open = !fifo_full && fifo_ready;
    eg = '0; er = '0; ew = 1'b0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      er[m_owner] = open;
      ew          = open && req_valid[m_owner];
      ed          = req_data[m_owner*DW +: DW];
    end
    e_vec = {eg, er, ew, ed};
    if (m_owner < 0) begin
      if (fifo_ready && req_valid != '0) begin m_owner = pick(m_last); m_cnt = 0; end
    end else if (!fifo_ready) begin
      m_owner = -1;
    end else if ((ew && m_cnt + 1 == MB) || !req_valid[m_owner]) begin
      m_last = m_owner; m_owner = pick(m_owner); m_cnt = 0;
    end else if (ew) begin
      m_cnt++;
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'((i << 6) | (seq[i] % 64));
  endtask

  task automatic note_accept();
    for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) seq[i]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; fifo_full = 1'b0; fifo_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < NR; i++) seq[i] = 5 + i * 7;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) seq[i] = 5 + i * 7;
    req_valid = 3'b011; fifo_ready = 1'b1; fifo_full = 1'b0;
    drive_data();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL reset_grant got %b exp 000", grant); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b exp 0", fifo_wr_en); end
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready got %b exp 000", req_ready); end
    n_cmp++; if (fifo_wr_data !== '0) begin n_err++; $display("FAIL reset_data got %h exp 00", fifo_wr_data); end
  endtask

  task automatic test_first_grant();
    do_reset();
    req_valid = 3'b011; drive_data(); #1;
    model_step();
    n_cmp++; if (obs !== e_vec) begin n_err++; $display("FAIL first_model c=0 got %h exp %h", obs, e_vec); end
    n_cmp++; if ({grant, fifo_wr_en} !== 4'b0000) begin n_err++; $display("FAIL first_idle got %b/%b exp 000/0", grant, fifo_wr_en); end
    note_accept(); @(negedge clk);
    drive_data(); #1;
    model_step();
    n_cmp++; if (obs !== e_vec) begin n_err++; $display("FAIL first_model c=1 got %h exp %h", obs, e_vec); end
    n_cmp++; if ({grant, fifo_wr_en, fifo_wr_data} !== {3'b001, 1'b1, 8'h05}) begin
      n_err++; $display("FAIL first_write got %b/%b/%h exp 001/1/05", grant, fifo_wr_en, fifo_wr_data); end
    note_accept(); @(negedge clk);
  endtask

  task automatic test_rotation();
    int rxs [NR];
    int k, own;
    do_reset();
    for (int i = 0; i < NR; i++) rxs[i] = seq[i];
    k = 0;
    req_valid = 3'b011;
    for (int c = 0; c < 25; c++) begin
      drive_data(); #1;
      model_step();
      n_cmp++; if (obs !== e_vec) begin n_err++; $display("FAIL rot_model c=%0d got %h exp %h", c, obs, e_vec); end
      if (c > 0) begin
        n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL rot_gap c=%0d got %b exp 1", c, fifo_wr_en); end
      end
      if (fifo_wr_en) begin
        own = (k / MB) % 2;
        n_cmp++; if (fifo_wr_data !== DW'((own << 6) | (rxs[own] % 64))) begin
          n_err++; $display("FAIL rot_data beat=%0d got %h exp %h", k, fifo_wr_data, DW'((own << 6) | (rxs[own] % 64))); end
        rxs[own]++; k++;
      end
      note_accept(); @(negedge clk);
    end
  endtask

  task automatic test_full_stall();
    logic [NR-1:0] tg [0:8];
    logic          tw [0:8];
    tg = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    tw = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    req_valid = 3'b011;
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      drive_data(); #1;
      model_step();
      n_cmp++; if (obs !== e_vec) begin n_err++; $display("FAIL full_model c=%0d got %h exp %h", c, obs, e_vec); end
      n_cmp++; if (grant !== tg[c] || fifo_wr_en !== tw[c]) begin
        n_err++; $display("FAIL full_seq c=%0d got %b/%b exp %b/%b", c, grant, fifo_wr_en, tg[c], tw[c]); end
      if (fifo_full) begin
        n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL full_ready c=%0d got %b exp 000", c, req_ready); end
      end
      note_accept(); @(negedge clk);
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_drop();
    logic [NR-1:0] tv [0:9];
    logic [NR-1:0] tg [0:9];
    logic          tw [0:9];
    tv = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010};
    tg = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
    tw = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid = tv[c];
      drive_data(); #1;
      model_step();
      n_cmp++; if (obs !== e_vec) begin n_err++; $display("FAIL drop_model c=%0d got %h exp %h", c, obs, e_vec); end
      n_cmp++; if (grant !== tg[c] || fifo_wr_en !== tw[c]) begin
        n_err++; $display("FAIL drop_seq c=%0d got %b/%b exp %b/%b", c, grant, fifo_wr_en, tg[c], tw[c]); end
      note_accept(); @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_ready_drop();
    logic          tr [0:7];
    logic [NR-1:0] tg [0:7];
    logic          tw [0:7];
    tr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tg = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001};
    tw = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    req_valid = 3'b011;
    for (int c = 0; c < 8; c++) begin
      fifo_ready = tr[c];
      drive_data(); #1;
      model_step();
      n_cmp++; if (obs !== e_vec) begin n_err++; $display("FAIL rdy_model c=%0d got %h exp %h", c, obs, e_vec); end
      n_cmp++; if (grant !== tg[c] || fifo_wr_en !== tw[c]) begin
        n_err++; $display("FAIL rdy_seq c=%0d got %b/%b exp %b/%b", c, grant, fifo_wr_en, tg[c], tw[c]); end
      if (c < 7) begin note_accept(); @(negedge clk); end
    end
    // still mid-burst: assert reset between clock edges
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (grant !== '0 || fifo_wr_en !== 1'b0) begin
      n_err++; $display("FAIL async_reset got %b/%b exp 000/0", grant, fifo_wr_en); end
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    model_reset();
  endtask

  task automatic test_random();
    int            sent [NR], rx [NR], wt [NR], mx [NR];
    logic [NR-1:0] acc;
    int            cyc, own;
    bit            done;
    do_reset();
    for (int i = 0; i < NR; i++) begin sent[i] = 0; rx[i] = 0; wt[i] = 0; mx[i] = 0; end
    acc = '0; cyc = 0; done = 1'b0;
    do begin
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          sent[i]++;
          req_valid[i] = (sent[i] < 1000) && ($urandom_range(3, 0) != 0);
        end else if (!req_valid[i] && sent[i] < 1000) begin
          req_valid[i] = ($urandom_range(1, 0) == 1);
        end
        req_data[i*DW +: DW] = DW'((i << 6) | (sent[i] % 64));
      end
      fifo_full = ($urandom_range(3, 0) == 0);
      #1;
      model_step();
      n_cmp++; if (obs !== e_vec) begin n_err++; $display("FAIL rand_model c=%0d got %h exp %h", cyc, obs, e_vec); end
      acc = req_valid & req_ready;
      if (fifo_wr_en) begin
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL rand_wr_full c=%0d got full=%b exp 0", cyc, fifo_full); end
        own = int'(fifo_wr_data[7:6]);
        n_cmp++;
        if (own >= NR) begin
          n_err++; $display("FAIL rand_owner c=%0d got %0d exp <%0d", cyc, own, NR);
        end else begin
          if (fifo_wr_data[5:0] !== 6'(rx[own] % 64)) begin
            n_err++; $display("FAIL rand_order c=%0d req=%0d got %h exp %h", cyc, own, fifo_wr_data[5:0], 6'(rx[own] % 64)); end
          rx[own]++;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) wt[i] = 0;
        else if (req_valid[i] && fifo_wr_en) begin
          wt[i]++;
          if (wt[i] > mx[i]) mx[i] = wt[i];
        end
      end
      done = 1'b1;
      for (int i = 0; i < NR; i++) if (sent[i] + int'(acc[i]) < 1000) done = 1'b0;
      cyc++;
      @(negedge clk);
    end while (!done && cyc < 40000);
    req_valid = '0; fifo_full = 1'b0;
    n_cmp++; if (!done) begin n_err++; $display("FAIL rand_timeout got %0d cycles exp completion", cyc); end
    for (int i = 0; i < NR; i++) begin
      n_cmp++; if (rx[i] != 1000) begin n_err++; $display("FAIL rand_count req=%0d got %0d exp 1000", i, rx[i]); end
      n_cmp++; if (mx[i] > 2 * MB) begin n_err++; $display("FAIL rand_starve req=%0d got %0d exp <=%0d", i, mx[i], 2 * MB); end
    end
  endtask

  initial begin
    req_valid = '0; req_data = '0; fifo_full = 1'b0; fifo_ready = 1'b0;
    model_reset();
    test_reset();
    test_first_grant();
    test_rotation();
    test_full_stall();
    test_drop();
    test_ready_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of fifo_sync among NUM_REQ valid/ready byte producers, such as the UART RX path and a loopback/test source. It grants one requester at a time, holds the grant for up to MAX_BURST beats and then rotates. Write enable and data are combinational from the registered grant, so fifo_full gates writes in the same cycle. It sits between the producers and fifo_sync; skid_buffer drains the FIFO downstream.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 8, data width per requester
MAX_BURST, 4, max beats per grant before forced rotation (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester data valid
req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-requester accept
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_data  out  DATA_WIDTH  FIFO write data
fifo_full  in  1  FIFO full
fifo_ready  in  1  FIFO initialised and usable
grant  out  NUM_REQ  one-hot current grant (registered), all-zero when idle

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, last_grant=NUM_REQ-1 (req 0 wins first), beat_cnt=0. Outputs fifo_wr_en=0, req_ready=0, fifo_wr_data=0.
- Transfer (beat) on requester g: grant[g] & req_valid[g] & ~fifo_full & fifo_ready.
  - Outputs: fifo_wr_en=beat; req_ready[g]=grant[g] & ~fifo_full & fifo_ready, other readies 0.
  - fifo_wr_data = req_data of g when any grant, else 0.
- Requesters hold valid and data until accepted; the arbiter never writes when fifo_full=1.
- States: IDLE, GRANT.
- IDLE, fifo_ready=1 and any req_valid:
  - Pick the first valid index searching from last_grant+1 with wrap modulo NUM_REQ.
  - Load grant one-hot next cycle, beat_cnt=0, go to GRANT.
  - Latency: valid seen in cycle N, earliest write in cycle N+1.
- GRANT, release conditions, evaluated each cycle:
  - (a) beat occurs and beat_cnt+1==MAX_BURST;
  - (b) req_valid[g]=0;
  - (c) fifo_ready=0.
- On release by (a) or (b):
  - last_grant<=g.
  - If any req_valid is set, re-arbitrate in the same cycle (search from g+1; g may be re-granted if it is the only one valid), load the new grant with beat_cnt=0, and stay in GRANT, giving back-to-back writes with no bubble.
  - Otherwise grant<=0 and go to IDLE.
- On release by (c): grant<=0, go to IDLE, last_grant unchanged.
- No release: beat_cnt increments on each beat and holds otherwise.
- fifo_full=1 while granted: no write, grant held, beat_cnt held; the burst resumes when full clears.
- beat_cnt width: $clog2(MAX_BURST+1); never exceeds MAX_BURST-1 while in GRANT.
- Simultaneous final beat and req_valid drop: treated as condition (a); the beat is written.
- rst asserted mid-burst: immediate async clear to reset values; no partial write is issued after reset.

Test Plan:
1. Reset, then fifo_ready=1 and req_valid=2'b11 at cycle N:
   - grant=2'b01 at N+1, fifo_wr_en=1 with req0 data at N+1.
   - All outputs are 0 during reset.
2. MAX_BURST=4, both requesters continuously valid with incrementing data:
   - FIFO receives 4 req0 bytes, 4 req1 bytes, 4 req0 bytes, and so on.
   - fifo_wr_en stays high continuously, with no idle cycle at rotations.
3. fifo_full=1 for 3 cycles after the 2nd beat of req0's burst:
   - fifo_wr_en=0 and req_ready=0 for those cycles; grant stays 01.
   - After full clears, exactly 2 more req0 beats, then rotation to req1.
4. Only req0 valid, dropping after 2 beats; req1 asserts 5 cycles later:
   - grant goes to 0 and IDLE after the drop.
   - req1 is granted one cycle after its assertion.
5. fifo_ready deasserted mid-burst:
   - Next cycle grant=0 and no writes while it is low.
   - On re-assertion, arbitration resumes. Separately, rst=0 mid-burst clears grant and fifo_wr_en asynchronously.
6. NUM_REQ=3, random valid/data and random fifo_full, 1000 bytes per requester:
   - Scoreboard shows per-requester order preserved, no loss or duplication.
   - fifo_wr_en never asserts with fifo_full=1; no requester starves beyond 2*MAX_BURST beats of others.
